// File: rtl/syscall_print_engine_pkg.sv
// Shared definitions for the syscall print engine.
//   - syscall codes recognised in $v0
//   - FSM state encoding
//   - default legal data-memory window
package syscall_print_engine_pkg;

    localparam logic [31:0] SYS_PRINT_STR  = 32'd4;
    localparam logic [31:0] SYS_PRINT_CHAR = 32'd11;
    localparam logic [31:0] SYS_EXIT       = 32'd10;

    localparam logic [31:0] MEM_BASE_DEF   = 32'h7FF0_0000;
    localparam logic [31:0] MEM_TOP_DEF    = 32'h7FFF_FFFF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EMIT  = 2'd2,
        ST_HALT  = 2'd3
    } state_t;

endpackage

// File: rtl/syscall_print_engine_if.sv
// Memory print-read port and console character port of the print engine.
//   print_addr  word-aligned read address (engine -> memory)
//   print_data  combinational read data   (memory -> engine)
//   char_valid  character available       (engine -> console)
//   char_data   ASCII character           (engine -> console)
//   char_ready  console accepts character (console -> engine)
interface syscall_print_engine_if;
    logic [31:0] print_addr;
    logic [31:0] print_data;
    logic        char_valid;
    logic [7:0]  char_data;
    logic        char_ready;

    modport master (
        output print_addr, char_valid, char_data,
        input  print_data, char_ready
    );

    modport slave (
        input  print_addr, char_valid, char_data,
        output print_data, char_ready
    );
endinterface

// File: rtl/syscall_print_engine_byte_lane_select.sv
// Big-endian byte extraction from a 32-bit word; reusable for lb/sb paths.
//   word      in  32  memory word
//   offset    in  2   byte offset (0 selects [31:24], 3 selects [7:0])
//   byte_out  out 8   selected byte
module byte_lane_select (
    input  logic [31:0] word,
    input  logic [1:0]  offset,
    output logic [7:0]  byte_out
);
    always_comb begin
        byte_out = 8'h00;
        case (offset)
            2'd0: byte_out = word[31:24];
            2'd1: byte_out = word[23:16];
            2'd2: byte_out = word[15:8];
            2'd3: byte_out = word[7:0];
            default: byte_out = 8'h00;
        endcase
    end
endmodule

// File: rtl/syscall_print_engine.sv
// Syscall side engine serving print_string (4), print_char (11) and exit (10)
// for the memory stage. Strings are walked byte by byte from $a0 up to the
// first NUL and emitted on a valid/ready console port while the pipeline is
// stalled.
//   clk, rst_n   clock / async active-low reset
//   sig_syscall  syscall in M this cycle
//   v0, a0       syscall code and argument
//   bus          memory print-read port + console port (master side)
//   sig_stall    freeze F/D/E/M
//   sig_halt     sticky exit indication
//   sig_err      one-cycle pulse: address out of range or MAX_LEN truncation
module syscall_print_engine
    import syscall_print_engine_pkg::*;
#(
    parameter logic [31:0] MEM_BASE = MEM_BASE_DEF,
    parameter logic [31:0] MEM_TOP  = MEM_TOP_DEF,
    parameter int          MAX_LEN  = 256
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          sig_syscall,
    input  logic [31:0]                   v0,
    input  logic [31:0]                   a0,
    syscall_print_engine_if.master        bus,
    output logic                          sig_stall,
    output logic                          sig_halt,
    output logic                          sig_err
);
    localparam int CNT_W = $clog2(MAX_LEN + 1);

    state_t           state, state_n;
    logic [31:0]      ptr, ptr_n;
    logic [CNT_W-1:0] count, count_n;
    logic             single, single_n;
    logic [7:0]       char_data, char_data_n;
    logic             halt, halt_n;

    logic [7:0]       lane;
    logic             in_range;
    logic [31:0]      print_addr;
    logic             char_valid;

    byte_lane_select u_lane (
        .word     (bus.print_data),
        .offset   (ptr[1:0]),
        .byte_out (lane)
    );

    assign in_range = (ptr >= MEM_BASE) && (ptr <= MEM_TOP);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            ptr       <= '0;
            count     <= '0;
            single    <= 1'b0;
            char_data <= 8'h00;
            halt      <= 1'b0;
        end else begin
            state     <= state_n;
            ptr       <= ptr_n;
            count     <= count_n;
            single    <= single_n;
            char_data <= char_data_n;
            halt      <= halt_n;
        end
    end

    always_comb begin
        state_n     = state;
        ptr_n       = ptr;
        count_n     = count;
        single_n    = single;
        char_data_n = char_data;
        halt_n      = halt;
        sig_stall   = 1'b0;
        sig_err     = 1'b0;
        print_addr  = 32'h0;
        char_valid  = 1'b0;

        case (state)
            ST_IDLE: begin
                // The request cycle itself stalls so the syscall stays in M.
                if (sig_syscall) begin
                    case (v0)
                        SYS_PRINT_STR: begin
                            sig_stall = 1'b1;
                            ptr_n     = a0;
                            count_n   = '0;
                            state_n   = ST_FETCH;
                        end
                        SYS_PRINT_CHAR: begin
                            sig_stall   = 1'b1;
                            char_data_n = a0[7:0];
                            single_n    = 1'b1;
                            state_n     = ST_EMIT;
                        end
                        SYS_EXIT: begin
                            halt_n  = 1'b1;
                            state_n = ST_HALT;
                        end
                        default: ;
                    endcase
                end
            end
            ST_FETCH: begin
                sig_stall  = 1'b1;
                print_addr = {ptr[31:2], 2'b00};
                // Range is checked before the byte so a wrapped pointer never
                // reads memory data into the console.
                if (!in_range) begin
                    sig_err = 1'b1;
                    state_n = ST_IDLE;
                end else if (lane == 8'h00) begin
                    state_n = ST_IDLE;
                end else if (count == CNT_W'(MAX_LEN)) begin
                    sig_err = 1'b1;
                    state_n = ST_IDLE;
                end else begin
                    char_data_n = lane;
                    single_n    = 1'b0;
                    state_n     = ST_EMIT;
                end
            end
            ST_EMIT: begin
                sig_stall  = 1'b1;
                char_valid = 1'b1;
                if (bus.char_ready) begin
                    count_n = count + CNT_W'(1);
                    ptr_n   = ptr + 32'd1;
                    state_n = single ? ST_IDLE : ST_FETCH;
                end
            end
            ST_HALT: ;
            default: state_n = ST_IDLE;
        endcase
    end

    assign bus.print_addr = print_addr;
    assign bus.char_valid = char_valid;
    assign bus.char_data  = char_data;
    assign sig_halt       = halt;
endmodule
